// File: rtl/led_pattern_gen.sv
// led_pattern_gen: shared prescaler and PWM timebase driving N_CH LED channels.
// Each channel is independently OFF, ON, fixed-duty PWM or BREATHE (triangle
// brightness sweep), configured through a single-cycle write port.
module led_pattern_gen #(
  parameter int N_CH       = 4,
  parameter int PRESCALE_W = 16,
  parameter int PWM_W      = 8,
  parameter int CH_W       = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [PWM_W-1:0]      cfg_duty,
  output logic                  cfg_err,
  output logic                  tick,
  output logic                  frame,
  output logic [N_CH-1:0]       led_out
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // One extra bit so N_CH itself is representable when N_CH == 2^CH_W.
  localparam int                  CH_CMP_W = CH_W + 1;
  localparam logic [CH_CMP_W-1:0] LP_N_CH  = CH_CMP_W'(N_CH);
  localparam logic [PWM_W-1:0]    LP_MAX   = '1;

  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_tick;
  logic                  r_frame;
  logic                  r_err;
  logic [PWM_W-1:0]      r_base;
  logic [N_CH-1:0]       r_led;

  mode_e                 r_mode   [N_CH];
  logic [PWM_W-1:0]      r_duty   [N_CH];
  logic [PWM_W-1:0]      r_bright [N_CH];
  dir_e                  r_dir    [N_CH];

  logic                  w_ptick;
  logic                  w_wrap;
  logic                  w_cfg_ok;
  logic [N_CH-1:0]       w_wr_sel;
  logic [N_CH-1:0]       w_level;
  logic [PWM_W-1:0]      w_bright_nxt [N_CH];
  dir_e                  w_dir_nxt    [N_CH];

  // Prescaler compare is >= so lowering prescale below the count wraps at once.
  assign w_ptick  = (r_pcnt >= prescale);
  // Frame wrap: the cycle in which base advances from its maximum back to 0.
  assign w_wrap   = r_tick && (r_base == LP_MAX);
  assign w_cfg_ok = ({1'b0, cfg_ch} < LP_N_CH);

  // Prescaler: count up, reload to 0 and pulse tick when the count reaches prescale.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!reset_n) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else if (w_ptick) begin
      r_pcnt <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pcnt <= r_pcnt + PRESCALE_W'(1);
      r_tick <= 1'b0;
    end
  end

  // PWM timebase: advance once per tick; frame marks the cycle base is back at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base  <= '0;
      r_frame <= 1'b0;
    end else begin
      if (r_tick) r_base <= r_base + PWM_W'(1);
      r_frame <= w_wrap;
    end
  end

  // Decode the write strobe into a one-hot per-channel select.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_wr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_wr_sel[i] = cfg_we && w_cfg_ok && (cfg_ch == CH_W'(i));
    end
  end

  // Next triangle step per channel: bounce at max and at zero.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_bright_nxt[i] = r_bright[i];
      w_dir_nxt[i]    = r_dir[i];
      if (r_dir[i] == DIR_UP) begin
        if (r_bright[i] == LP_MAX) begin
          w_dir_nxt[i]    = DIR_DOWN;
          w_bright_nxt[i] = LP_MAX - PWM_W'(1);
        end else begin
          w_bright_nxt[i] = r_bright[i] + PWM_W'(1);
        end
      end else begin
        if (r_bright[i] == '0) begin
          w_dir_nxt[i]    = DIR_UP;
          w_bright_nxt[i] = PWM_W'(1);
        end else begin
          w_bright_nxt[i] = r_bright[i] - PWM_W'(1);
        end
      end
    end
  end

  // Channel state: a write to a channel overrides that channel's breathe step.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the per-channel arrays are plain flops, not RAM, so they are reset
    // like any other register.
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_mode[i]   <= MODE_OFF;
        r_duty[i]   <= '0;
        r_bright[i] <= '0;
        r_dir[i]    <= DIR_UP;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_wr_sel[i]) begin
          r_mode[i] <= mode_e'(cfg_mode);
          r_duty[i] <= cfg_duty;
          if (mode_e'(cfg_mode) == MODE_BREATHE) begin
            r_bright[i] <= '0;
            r_dir[i]    <= DIR_UP;
          end
        end else if (w_wrap && (r_mode[i] == MODE_BREATHE)) begin
          r_bright[i] <= w_bright_nxt[i];
          r_dir[i]    <= w_dir_nxt[i];
        end
      end
    end
  end

  // Per-channel level from mode, duty/brightness and the shared base.
  always_comb begin
    w_level = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (r_mode[i])
        MODE_OFF:     w_level[i] = 1'b0;
        MODE_ON:      w_level[i] = 1'b1;
        MODE_PWM:     w_level[i] = (r_base < r_duty[i]);
        MODE_BREATHE: w_level[i] = (r_base < r_bright[i]);
        default:      w_level[i] = 1'b0;
      endcase
    end
  end

  // Register LED drive and the bad-address flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= '0;
      r_err <= 1'b0;
    end else begin
      r_led <= w_level;
      r_err <= cfg_we && !w_cfg_ok;
    end
  end

  assign tick    = r_tick;
  assign frame   = r_frame;
  assign cfg_err = r_err;
  assign led_out = r_led;

endmodule
